// File: rtl/sound_sequencer.sv
// Sound event sequencer: turns ball-stage sound codes into timed square-wave tones.
// Optional macro SOUND_QUEUE_EN adds a one-entry pending register for dropped events.
module sound_sequencer #(
    parameter int DUR_CYCLES = 2500000,
    parameter int TONE_SHIFT = 0,
    parameter int HP_1       = 28409,
    parameter int HP_2       = 14205,
    parameter int HP_3       = 7102,
    parameter int HP_4A      = 23901,
    parameter int HP_4B      = 31888,
    parameter int HP_4C      = 47710
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sound_code,
    input  logic       sound_trig,
    input  logic       sound_en,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] cur_code
);

    typedef enum logic [2:0] {IDLE, TONE, SEQ_A, SEQ_B, SEQ_C} state_t;

    // Reload value is half-period minus one; a zero half-period acts as one.
    function automatic int shrink(input int hp);
        int s;
        s = hp >>> TONE_SHIFT;
        return (s < 1) ? 0 : s - 1;
    endfunction

    localparam logic [16:0] L1  = 17'(shrink(HP_1));
    localparam logic [16:0] L2  = 17'(shrink(HP_2));
    localparam logic [16:0] L3  = 17'(shrink(HP_3));
    localparam logic [16:0] L4A = 17'(shrink(HP_4A));
    localparam logic [16:0] L4B = 17'(shrink(HP_4B));
    localparam logic [16:0] L4C = 17'(shrink(HP_4C));
    localparam logic [21:0] DUR_LOAD = 22'(DUR_CYCLES - 1);

    function automatic logic [16:0] code_hp(input logic [2:0] c);
        unique case (c)
            3'd1:    return L1;
            3'd2:    return L2;
            3'd3:    return L3;
            default: return L4A;
        endcase
    endfunction

    state_t      state;
    logic [2:0]  code_prev;
    logic [2:0]  code_n;
    logic [21:0] dur_cnt;
    logic [16:0] hp_cnt;
    logic [16:0] run_hp;
    logic        level;
    logic        ev;
    logic        last;
    logic        accept;
    logic        drop;
    logic        start;
    logic [2:0]  start_code;
    logic [2:0]  pend;

    always_comb begin
        code_n = (sound_code >= 3'd1 && sound_code <= 3'd4) ? sound_code : 3'd0;
        ev     = (sound_trig || code_n != code_prev) && code_n != 3'd0;
        last   = dur_cnt == 22'd0 && (state == TONE || state == SEQ_C);
        accept = ev && (state == IDLE || last || code_n >= cur_code);
        drop   = ev && !accept;
        start  = accept || (last && pend != 3'd0);
        start_code = accept ? code_n : pend;
        unique case (state)
            TONE:    run_hp = code_hp(cur_code);
            SEQ_B:   run_hp = L4B;
            SEQ_C:   run_hp = L4C;
            default: run_hp = L4A;
        endcase
    end

`ifdef SOUND_QUEUE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 3'd0;
        end else if (start && !accept) begin
            pend <= 3'd0;
        end else if (drop && code_n > pend) begin
            pend <= code_n;
        end
    end
`else
    assign pend = 3'd0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cur_code  <= 3'd0;
            level     <= 1'b0;
            speaker   <= 1'b0;
            code_prev <= 3'd0;
            dur_cnt   <= 22'd0;
            hp_cnt    <= 17'd0;
        end else begin
            code_prev <= code_n;
            speaker   <= level & sound_en;
            if (start) begin
                state    <= (start_code == 3'd4) ? SEQ_A : TONE;
                busy     <= 1'b1;
                cur_code <= start_code;
                level    <= 1'b1;
                dur_cnt  <= DUR_LOAD;
                hp_cnt   <= code_hp(start_code);
            end else if (state != IDLE) begin
                if (dur_cnt == 22'd0) begin
                    unique case (state)
                        SEQ_A: begin
                            state   <= SEQ_B;
                            level   <= 1'b1;
                            dur_cnt <= DUR_LOAD;
                            hp_cnt  <= L4B;
                        end
                        SEQ_B: begin
                            state   <= SEQ_C;
                            level   <= 1'b1;
                            dur_cnt <= DUR_LOAD;
                            hp_cnt  <= L4C;
                        end
                        default: begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            cur_code <= 3'd0;
                            level    <= 1'b0;
                        end
                    endcase
                end else begin
                    dur_cnt <= dur_cnt - 22'd1;
                    if (hp_cnt == 17'd0) begin
                        hp_cnt <= run_hp;
                        level  <= ~level;
                    end else begin
                        hp_cnt <= hp_cnt - 17'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
Downstream consumer of the ball stage's sound event outputs (3-bit sound code plus the erase-enable pulse). Turns each event into a timed square-wave tone on a 1-bit speaker pin.
- Codes 1–3 (wall/block hits): single tone.
- Code 4 (ball lost): three-note descending jingle.
Sits between ball logic and the board audio pin, in the 25 MHz pixel-clock domain.

Parameters:
DUR_CYCLES, 2500000, clock cycles per note (100 ms at 25 MHz); max 2^22-1.
TONE_SHIFT, 0, right-shift applied to every half-period constant; benches use larger values to shorten periods.
HP_1, 28409, half-period in cycles for code 1 (440 Hz).
HP_2, 14205, half-period for code 2 (880 Hz).
HP_3, 7102, half-period for code 3 (1760 Hz).
HP_4A / HP_4B / HP_4C, 23901 / 31888 / 47710, half-periods for the code-4 notes (523 / 392 / 262 Hz).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
sound_code  in  3  event code from ball stage; level-held, codes 0..4; 5..7 treated as 0.
sound_trig  in  1  one-cycle event strobe (wired to erase_enable).
sound_en  in  1  1 = audible; 0 forces speaker low, FSM keeps running.
speaker  out  1  square-wave audio output.
busy  out  1  high while any note is playing.
cur_code  out  3  code currently playing; 0 when idle.

Behaviour:
- Reset values (async assert, sync-free release):
  - speaker=0, busy=0, cur_code=0, state=IDLE.
  - code_prev=0; all counters 0; pending cleared.
- Event detection:
  - code_prev is registered every cycle.
  - event = (sound_trig || sound_code != code_prev) && sound_code in 1..4.
  - Trig and code change in the same cycle count as one event.
  - Code 0 or 5..7 never starts a tone.
- States: IDLE, TONE, SEQ_A, SEQ_B, SEQ_C.
- Start latency: event sampled at edge N; at edge N:
  - state goes to TONE (codes 1–3) or SEQ_A (code 4);
  - busy=1, cur_code=code;
  - internal square level=1;
  - dur_cnt=DUR_CYCLES-1, hp_cnt=(HP_x>>TONE_SHIFT)-1.
- Waveform: hp_cnt decrements each cycle. At 0 it reloads and the square level toggles, so the period is 2*(HP_x>>TONE_SHIFT) cycles. If the shifted HP is 0, it is treated as 1.
- Note timing: dur_cnt decrements each cycle. At 0:
  - TONE goes to IDLE;
  - SEQ_A goes to SEQ_B, SEQ_B goes to SEQ_C (counters reloaded, level=1);
  - SEQ_C goes to IDLE.
  - On entering IDLE: busy=0, cur_code=0, level=0.
- Each note lasts exactly DUR_CYCLES cycles. The code-4 jingle lasts 3*DUR_CYCLES with no gaps.
- speaker = level & sound_en, registered, so it lags level by 1 cycle.
- Preemption while busy:
  - If the new code >= cur_code, playback restarts immediately with the new code, counters reloaded. This includes restarting the same code.
  - If the new code < cur_code, the event is dropped.
  - A code-4 event during a jingle restarts at SEQ_A.
- An event arriving in the same cycle that a note expires is treated as an event in IDLE and starts at the same edge.
- Reset asserted mid-note: immediate return to reset values; no residual toggle.
- Counter widths: dur_cnt 22 bits, hp_cnt 17 bits; no wrap when loaded within the parameter limits.

Optional Feature:
Macro SOUND_QUEUE_EN.
- Defined:
  - A one-entry pending register holds the highest-code event dropped under the preemption rule.
  - A later dropped event replaces the entry only if its code is higher.
  - When the current note or sequence ends, the pending code starts on that same edge instead of going to IDLE (busy stays 1), and pending is cleared.
  - Reset clears pending.
- Undefined: dropped events are discarded; no pending register is synthesized.

Test Plan:
1. TONE_SHIFT=10, DUR_CYCLES=200. sound_code 0→2 at cycle 10 → busy=1 at cycle 11; speaker toggles every 13 cycles (14205>>10); busy=0 and speaker=0 after exactly 200 cycles.
2. Same parameters, code 4 event → cur_code=4 for 600 cycles; half-periods 23, 31, 46 cycles in sequence; then IDLE.
3. During a code-3 tone, pulse sound_trig with code 1 → ignored, tone ends on schedule. Then a code-3 trig mid-tone → restarts, 200 more cycles from the restart.
4. sound_trig=1 and code change 1→2 in the same cycle → a single restart, not two; sound_code=6 with trig → no tone.
5. sound_en=0 during a tone → speaker=0 but busy/cur_code unchanged. Assert reset mid-tone → all outputs 0 immediately; after release, code_prev=0 and no spurious event.
6. With SOUND_QUEUE_EN: code-3 playing, then trigs with codes 1 and 2 → code 2 plays right after code 3 ends with busy held high; code 1 is lost.
